dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates and sequences a single-port, synchronous-read data RAM between two masters. Master 0 is the core MEM stage and master 1 is a DMA/debug port. The block generates byte-lane write enables and replicated write data from the RISC-V func3 size code, and returns sign- or zero-extended load data one cycle after grant. It sits between the core's load/store path and the data RAM macro.

Parameters:
RAM_AW, 12, RAM word-address width (RAM depth = 2^RAM_AW words)
MAX_WAIT, 4, cycles m1 may be denied while requesting before it overrides m0 priority

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
m0_req  in  1  master 0 access request; held until m0_gnt
m0_we  in  1  1 = store, 0 = load
m0_addr  in  32  byte address
m0_wdata  in  32  store data, right-aligned
m0_func3  in  3  RISC-V size/sign code
m0_gnt  out  1  request accepted this cycle
m0_rvalid  out  1  load data / error response valid
m0_rdata  out  32  extended load data
m0_err  out  1  misaligned or illegal func3; valid with gnt for stores, with rvalid for loads
m1_req, m1_we, m1_addr, m1_wdata, m1_func3, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0
ram_en  out  1  RAM access strobe
ram_we  out  4  byte write enables
ram_addr  out  RAM_AW  word address = addr[RAM_AW+1:2]
ram_wdata  out  32  lane-replicated store data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we = 0

Behaviour:
- FSM states: IDLE and RD_WAIT. Reset: state = IDLE, wait counter = 0, all rvalid/err/gnt = 0, ram_en = 0, ram_we = 0, rdata = 0.
- IDLE, winner selection: m0 wins unless m1 wait counter == MAX_WAIT, in which case m1 wins. gnt goes to the winner only, combinationally in the same cycle.
- Store grant: RAM write is driven that cycle; FSM stays IDLE. Back-to-back stores are accepted 1 per cycle.
- Load grant: ram_en = 1, ram_we = 0, owner is latched, FSM goes to RD_WAIT.
- RD_WAIT: owner's rvalid = 1, rdata = extended ram_rdata, no grants issued; FSM returns to IDLE next cycle. Load throughput is 1 per 2 cycles.
- Store lanes:
  - SB (000): we = 1 << addr[1:0], wdata = byte replicated ×4.
  - SH (001): we = 0011 (addr[1] = 0) or 1100, halfword replicated ×2.
  - SW (010): we = 1111.
- Load extension:
  - LB (000) sign-extends the selected byte; LBU (100) zero-extends it.
  - LH (001) sign-extends the selected halfword; LHU (101) zero-extends it.
  - LW (010) passes the word through.
- Errors: halfword access with addr[0] = 1, word access with addr[1:0] != 0, or func3 in {011, 110, 111}.
  - The request is granted with no RAM access (ram_en = 0).
  - Store: err pulses with gnt.
  - Load: FSM still enters RD_WAIT; rvalid = 1, err = 1, rdata = 0.
- Wait counter: increments (saturating at MAX_WAIT) each cycle m1_req = 1 and m1_gnt = 0, including in RD_WAIT. Clears on m1_gnt or when m1_req = 0.
- Simultaneous requests in RD_WAIT: both wait and arbitrate in the next IDLE cycle.
- rst in RD_WAIT: FSM goes to IDLE and the pending rvalid is never delivered.
- Address bits above RAM_AW+1 are ignored; decoding is done upstream.

Decomposition:
- Shared package/define file holds the func3 codes (LB/LH/LW/LBU/LHU, SB/SH/SW) and the FSM state encodings; reuse the existing INST_* defines.
- One natural sub-module: dmem_lane_align. It is purely combinational, instantiated once on the request path (we/wdata/err generation) and once on the response path (load extension).

Test Plan:
- m0 SW addr 0x10 data 0xDEADBEEF, then LW addr 0x10 -> gnt same cycle, ram_we = 1111, ram_addr = 4; rvalid next cycle, rdata = 0xDEADBEEF.
- m0 SB addr 0x13 data 0x80, then LB addr 0x13 and LBU addr 0x13 -> ram_we = 1000, ram_wdata = 0x80808080; LB rdata = 0xFFFFFF80, LBU rdata = 0x00000080.
- m0 LH addr 0x21 -> gnt, ram_en = 0, next cycle rvalid = 1, err = 1, rdata = 0; SW addr 0x22 -> gnt with err = 1, ram_we = 0000.
- m0 and m1 request continuously (MAX_WAIT = 4, stores) -> m0 granted 4 cycles, m1 granted on the 5th cycle, counter clears, pattern repeats.
- m0 LW granted while m1 store pending -> m1 gnt withheld in RD_WAIT, granted the next cycle.
- rst asserted in RD_WAIT -> no rvalid, all outputs at reset values next cycle, subsequent LW completes normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared func3 size/sign codes and FSM encoding for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store lanes/replication, load extension, alignment errors.
module dmem_lane_align
  import dmem_arbiter_pkg::*;
(
  input  logic        i_store,
  input  logic [2:0]  i_func3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [3:0]  o_lanes,
  output logic [31:0] o_data,
  output logic        o_err
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_data >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_lanes = '0;
    o_data  = '0;
    o_err   = 1'b0;
    if (f3_illegal(i_func3)) begin
      o_err = 1'b1;
    end else begin
      case (i_func3[1:0])
        2'b01:   o_err = i_addr_lo[0];
        2'b10:   o_err = |i_addr_lo;
        default: o_err = 1'b0;
      endcase
    end

    if (i_store) begin
      case (i_func3)
        INST_SB: begin
          o_lanes = 4'b0001 << i_addr_lo;
          o_data  = {4{i_data[7:0]}};
        end
        INST_SH: begin
          o_lanes = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_data  = {2{i_data[15:0]}};
        end
        INST_SW: begin
          o_lanes = 4'b1111;
          o_data  = i_data;
        end
        // Unsigned size codes have no store meaning; reject them like illegal codes.
        default: o_err = 1'b1;
      endcase
      if (o_err) o_lanes = '0;
    end else begin
      case (i_func3)
        INST_LB:  o_data = {{24{w_byte[7]}}, w_byte};
        INST_LBU: o_data = {24'h0, w_byte};
        INST_LH:  o_data = {{16{w_half[15]}}, w_half};
        INST_LHU: o_data = {16'h0, w_half};
        INST_LW:  o_data = i_data;
        default:  o_data = '0;
      endcase
      if (o_err) o_data = '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for a single-port sync-read data RAM.
// Stores complete in the grant cycle; loads return one cycle after grant.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int RAM_AW   = 12,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [2:0]        m0_func3,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [2:0]        m1_func3,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              m1_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t          r_state, w_state_nxt;
  logic            r_owner;
  logic [2:0]      r_func3;
  logic [1:0]      r_addr_lo;
  logic [CW-1:0]   r_wait_cnt;

  logic            w_sel_m1, w_any_req, w_we;
  logic [2:0]      w_func3;
  logic [1:0]      w_addr_lo;
  logic [31:0]     w_wdata;
  logic [RAM_AW-1:0] w_addr_word;
  logic [3:0]      w_req_lanes, w_rsp_lanes_unused;
  logic [31:0]     w_req_wdata, w_rsp_data;
  logic            w_req_err, w_rsp_err;
  logic            w_addr_unused;

  // m1 only jumps the queue once it has been starved for MAX_WAIT cycles.
  assign w_sel_m1    = m1_req && (!m0_req || (r_wait_cnt == CW'(MAX_WAIT)));
  assign w_any_req   = m0_req | m1_req;
  assign w_we        = w_sel_m1 ? m1_we    : m0_we;
  assign w_func3     = w_sel_m1 ? m1_func3 : m0_func3;
  assign w_wdata     = w_sel_m1 ? m1_wdata : m0_wdata;
  assign w_addr_lo   = w_sel_m1 ? m1_addr[1:0] : m0_addr[1:0];
  assign w_addr_word = w_sel_m1 ? m1_addr[RAM_AW+1:2] : m0_addr[RAM_AW+1:2];
  assign w_addr_unused = ^{m0_addr, m1_addr};

  dmem_lane_align u_req_align (
    .i_store   (w_we),
    .i_func3   (w_func3),
    .i_addr_lo (w_addr_lo),
    .i_data    (w_wdata),
    .o_lanes   (w_req_lanes),
    .o_data    (w_req_wdata),
    .o_err     (w_req_err)
  );

  dmem_lane_align u_rsp_align (
    .i_store   (1'b0),
    .i_func3   (r_func3),
    .i_addr_lo (r_addr_lo),
    .i_data    (ram_rdata),
    .o_lanes   (w_rsp_lanes_unused),
    .o_data    (w_rsp_data),
    .o_err     (w_rsp_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    m0_gnt = 1'b0;  m0_rvalid = 1'b0;  m0_rdata = '0;  m0_err = 1'b0;
    m1_gnt = 1'b0;  m1_rvalid = 1'b0;  m1_rdata = '0;  m1_err = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = w_addr_word;
    ram_wdata = '0;
    // Outputs are held quiet while rst is high so a pending load never surfaces.
    if (!rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            m0_gnt = !w_sel_m1;
            m1_gnt = w_sel_m1;
            ram_en = !w_req_err;
            if (w_we) begin
              ram_we    = w_req_lanes;
              ram_wdata = w_req_wdata;
              m0_err    = !w_sel_m1 && w_req_err;
              m1_err    = w_sel_m1 && w_req_err;
            end else begin
              w_state_nxt = ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          m0_rvalid   = !r_owner;
          m1_rvalid   = r_owner;
          m0_rdata    = r_owner ? 32'h0 : w_rsp_data;
          m1_rdata    = r_owner ? w_rsp_data : 32'h0;
          m0_err      = !r_owner && w_rsp_err;
          m1_err      = r_owner && w_rsp_err;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_func3    <= '0;
      r_addr_lo  <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_any_req && !w_we) begin
        r_owner   <= w_sel_m1;
        r_func3   <= w_func3;
        r_addr_lo <= w_addr_lo;
      end
      if (!m1_req || m1_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != CW'(MAX_WAIT)) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync-read RAM attached.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int RAM_AW = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_func3, m1_func3;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] mem [0:(1<<RAM_AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RAM_AW(RAM_AW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_func3(m0_func3), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_func3(m1_func3), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (|ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic drv0(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_func3 = f3;
  endtask

  task automatic drv1(input logic req, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_func3 = f3;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drv0(1'b0, 1'b0, 32'h0, 32'h0, INST_LW);
    drv1(1'b0, 1'b0, 32'h0, 32'h0, INST_LW);
    ram_rdata = '0;
    cyc(); cyc();
    rst = 1'b0;
    #3;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_rdata", m0_rdata, 0);

    // SW then LW at 0x10
    cyc(); drv0(1, 1, 32'h10, 32'hDEADBEEF, INST_SW); #3;
    chk("sw_gnt", m0_gnt, 1);
    chk("sw_m1_gnt", m1_gnt, 0);
    chk("sw_ram_en", ram_en, 1);
    chk("sw_ram_we", ram_we, 4'hF);
    chk("sw_ram_addr", ram_addr, 4);
    chk("sw_wdata", ram_wdata, 32'hDEADBEEF);
    chk("sw_err", m0_err, 0);
    cyc(); drv0(1, 0, 32'h10, 32'h0, INST_LW); #3;
    chk("lw_gnt", m0_gnt, 1);
    chk("lw_ram_en", ram_en, 1);
    chk("lw_ram_we", ram_we, 0);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lw_rvalid", m0_rvalid, 1);
    chk("lw_rdata", m0_rdata, 32'hDEADBEEF);
    chk("lw_err", m0_err, 0);
    chk("lw_m1_rvalid", m1_rvalid, 0);
    chk("lw_no_gnt", m0_gnt, 0);

    // SB at 0x13, then byte/half loads of the updated word 0x80ADBEEF
    cyc(); drv0(1, 1, 32'h13, 32'h00000080, INST_SB); #3;
    chk("sb_ram_we", ram_we, 4'b1000);
    chk("sb_wdata", ram_wdata, 32'h80808080);
    cyc(); drv0(1, 0, 32'h13, 32'h0, INST_LB); #3;
    chk("lb_gnt", m0_gnt, 1);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lb_rdata", m0_rdata, 32'hFFFFFF80);
    cyc(); drv0(1, 0, 32'h13, 32'h0, INST_LBU); #3;
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lbu_rdata", m0_rdata, 32'h00000080);
    cyc(); drv0(1, 0, 32'h12, 32'h0, INST_LH); #3;
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lh_rdata", m0_rdata, 32'hFFFF80AD);
    cyc(); drv0(1, 0, 32'h12, 32'h0, INST_LHU); #3;
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lhu_rdata", m0_rdata, 32'h000080AD);

    // SH upper half of word 5, read back unsigned
    cyc(); drv0(1, 1, 32'h16, 32'h00001234, INST_SH); #3;
    chk("sh_ram_we", ram_we, 4'b1100);
    chk("sh_wdata", ram_wdata, 32'h12341234);
    chk("sh_ram_addr", ram_addr, 5);
    cyc(); drv0(1, 0, 32'h16, 32'h0, INST_LHU); #3;
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("sh_readback", m0_rdata, 32'h00001234);

    // Error cases
    cyc(); drv0(1, 0, 32'h21, 32'h0, INST_LH); #3;
    chk("lh_mis_gnt", m0_gnt, 1);
    chk("lh_mis_ram_en", ram_en, 0);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("lh_mis_rvalid", m0_rvalid, 1);
    chk("lh_mis_err", m0_err, 1);
    chk("lh_mis_rdata", m0_rdata, 0);
    cyc(); drv0(1, 1, 32'h22, 32'hFFFFFFFF, INST_SW); #3;
    chk("sw_mis_gnt", m0_gnt, 1);
    chk("sw_mis_err", m0_err, 1);
    chk("sw_mis_ram_we", ram_we, 0);
    chk("sw_mis_ram_en", ram_en, 0);
    cyc(); drv0(1, 1, 32'h30, 32'h0, 3'b011); #3;
    chk("st_f3_illegal_err", m0_err, 1);
    chk("st_f3_illegal_we", ram_we, 0);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;

    // Continuous contention: m1 wins every 5th cycle
    for (int c = 1; c <= 10; c++) begin
      cyc();
      drv0(1, 1, 32'h40, 32'h1, INST_SW);
      drv1(1, 1, 32'h80, 32'h2, INST_SW);
      #3;
      chk($sformatf("arb_m0_gnt_%0d", c), m0_gnt, ((c % 5) != 0) ? 1 : 0);
      chk($sformatf("arb_m1_gnt_%0d", c), m1_gnt, ((c % 5) == 0) ? 1 : 0);
      chk($sformatf("arb_addr_%0d", c), ram_addr, ((c % 5) == 0) ? 32'h20 : 32'h10);
    end
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); drv1(0, 0, 32'h0, 32'h0, INST_LW); #3;

    // m1 store pending across an m0 load
    cyc(); drv0(1, 0, 32'h10, 32'h0, INST_LW); drv1(1, 1, 32'h84, 32'h55, INST_SW); #3;
    chk("rdw_m0_gnt", m0_gnt, 1);
    chk("rdw_m1_gnt0", m1_gnt, 0);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("rdw_m0_rvalid", m0_rvalid, 1);
    chk("rdw_m0_rdata", m0_rdata, 32'h80ADBEEF);
    chk("rdw_m1_gnt1", m1_gnt, 0);
    chk("rdw_ram_en", ram_en, 0);
    cyc(); #3;
    chk("rdw_m1_gnt2", m1_gnt, 1);
    chk("rdw_m1_we", ram_we, 4'hF);
    chk("rdw_m1_addr", ram_addr, 32'h21);
    chk("rdw_m1_wdata", ram_wdata, 32'h55);
    cyc(); drv1(1, 0, 32'h84, 32'h0, INST_LW); #3;
    chk("m1_lw_gnt", m1_gnt, 1);
    cyc(); drv1(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("m1_lw_rvalid", m1_rvalid, 1);
    chk("m1_lw_rdata", m1_rdata, 32'h55);
    chk("m1_lw_m0_rvalid", m0_rvalid, 0);

    // Reset while a load is outstanding
    cyc(); drv0(1, 0, 32'h10, 32'h0, INST_LW); #3;
    chk("rstrd_gnt", m0_gnt, 1);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); rst = 1'b1; #3;
    chk("rstrd_no_rvalid", m0_rvalid, 0);
    cyc(); rst = 1'b0; #3;
    chk("rstrd_after_rvalid", m0_rvalid, 0);
    chk("rstrd_after_ram_en", ram_en, 0);
    chk("rstrd_after_rdata", m0_rdata, 0);
    chk("rstrd_after_err", m0_err, 0);
    cyc(); drv0(1, 0, 32'h10, 32'h0, INST_LW); #3;
    chk("post_rst_lw_gnt", m0_gnt, 1);
    cyc(); drv0(0, 0, 32'h0, 32'h0, INST_LW); #3;
    chk("post_rst_rvalid", m0_rvalid, 1);
    chk("post_rst_rdata", m0_rdata, 32'h80ADBEEF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
